// File: rtl/io_interval_timer_pkg.sv
// io_interval_timer_pkg
//   Shared definitions for the IO interval timer: register byte offsets,
//   CONTROL/STATUS bit positions and a helper that forms a register's
//   absolute bus address. Software headers and the bench use the same values.
package io_interval_timer_pkg;

  // Register byte offsets from BASE_ADDRESS
  localparam logic [31:0] TIMER_CONTROL = 32'd0;
  localparam logic [31:0] TIMER_RELOAD  = 32'd4;
  localparam logic [31:0] TIMER_COUNT   = 32'd8;
  localparam logic [31:0] TIMER_STATUS  = 32'd12;

  // CONTROL bits
  localparam int CTRL_ENABLE_BIT      = 0;
  localparam int CTRL_AUTO_RELOAD_BIT = 1;

  // STATUS bits: expired is write-1-to-clear; writing 1 to bit1 clears miss_count
  localparam int STATUS_EXPIRED_BIT    = 0;
  localparam int STATUS_CLEAR_MISS_BIT = 1;
  localparam int STATUS_MISS_LSB       = 8;
  localparam int STATUS_MISS_MSB       = 15;

  localparam int                          MISS_COUNT_WIDTH = 8;
  localparam logic [MISS_COUNT_WIDTH-1:0] MISS_COUNT_MAX   = 8'hFF;

  function automatic logic [31:0] timer_reg_addr(input logic [31:0] base,
                                                 input logic [31:0] offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/io_interval_timer_prescaler.sv
// io_prescaler
//   Parameterized tick generator. While enabled, an internal counter runs
//   0..PRESCALE-1 and wraps; tick is high in the cycle the counter holds
//   PRESCALE-1. While disabled the counter is held at 0, so enabling always
//   starts a fresh period. A synchronous clear restarts the period.
// Ports:
//   clk    in  core clock
//   reset  in  synchronous, active-high
//   enable in  run the counter
//   clear  in  force the counter back to 0 on the next edge
//   tick   out one-cycle tick, once every PRESCALE enabled cycles
module io_prescaler #(
  parameter int PRESCALE = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  // One bit minimum so PRESCALE=1 still has a legal counter width
  localparam int                 CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    tick    = enable && (count_q == LAST);
    count_d = count_q + CNT_W'(1);
    if (clear || !enable || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/io_interval_timer.sv
// io_interval_timer
//   Memory-mapped countdown timer on the core's IO bus. Registers at
//   BASE_ADDRESS: +0 CONTROL (enable, auto_reload), +4 RELOAD, +8 COUNT (RO),
//   +12 STATUS (expired W1C, miss_count RO in [15:8], bit1 write clears it).
//   COUNT decrements once per prescaler tick; reaching expiry from 1 sets the
//   sticky expired flag and optionally reloads. Expiries that arrive while
//   expired is still set are counted in miss_count (saturating).
// Ports:
//   clk           in  core clock
//   reset         in  synchronous, active-high
//   io_address    in  IO byte address
//   io_read_en    in  one-cycle read strobe
//   io_write_en   in  one-cycle write strobe
//   io_write_data in  IO write data
//   io_read_data  out registered read data, 0 when the last read missed this block
//   timer_expired out registered copy of STATUS.expired
module io_interval_timer
  import io_interval_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS  = 32'd32,
  parameter int          PRESCALE      = 25,
  parameter int          COUNTER_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] io_address,
  input  logic        io_read_en,
  input  logic        io_write_en,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        timer_expired
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  logic                        enable_q, enable_d;
  logic                        auto_reload_q, auto_reload_d;
  logic [COUNTER_WIDTH-1:0]    reload_q, reload_d;
  logic [COUNTER_WIDTH-1:0]    count_q, count_d;
  logic                        expired_q, expired_d;
  logic [MISS_COUNT_WIDTH-1:0] miss_count_q, miss_count_d;
  logic [31:0]                 read_data_q, read_data_d;
  logic                        timer_expired_q, timer_expired_d;

  logic        sel_control, sel_reload, sel_count, sel_status;
  logic        wr_control, wr_reload, wr_status;
  logic        clear_expired, clear_miss, expire, tick;
  logic [31:0] read_value;

  // A RELOAD write restarts the prescaler period so the new count gets a full tick
  io_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .enable(enable_q),
    .clear (wr_reload),
    .tick  (tick)
  );

  always_comb begin
    sel_control = (io_address == timer_reg_addr(BASE_ADDRESS, TIMER_CONTROL));
    sel_reload  = (io_address == timer_reg_addr(BASE_ADDRESS, TIMER_RELOAD));
    sel_count   = (io_address == timer_reg_addr(BASE_ADDRESS, TIMER_COUNT));
    sel_status  = (io_address == timer_reg_addr(BASE_ADDRESS, TIMER_STATUS));

    wr_control    = io_write_en && sel_control;
    wr_reload     = io_write_en && sel_reload;
    wr_status     = io_write_en && sel_status;
    clear_expired = wr_status && io_write_data[STATUS_EXPIRED_BIT];
    clear_miss    = wr_status && io_write_data[STATUS_CLEAR_MISS_BIT];

    // Read mux built from current register values, so a read that coincides
    // with a write to the same register returns the pre-write value
    read_value = '0;
    if (sel_control) begin
      read_value[CTRL_ENABLE_BIT]      = enable_q;
      read_value[CTRL_AUTO_RELOAD_BIT] = auto_reload_q;
    end else if (sel_reload) begin
      read_value = 32'(reload_q);
    end else if (sel_count) begin
      read_value = 32'(count_q);
    end else if (sel_status) begin
      read_value[STATUS_EXPIRED_BIT]               = expired_q;
      read_value[STATUS_MISS_MSB:STATUS_MISS_LSB]  = miss_count_q;
    end

    enable_d      = enable_q;
    auto_reload_d = auto_reload_q;
    reload_d      = reload_q;
    count_d       = count_q;
    expired_d     = expired_q;
    miss_count_d  = miss_count_q;
    read_data_d   = read_data_q;
    expire        = 1'b0;

    if (io_read_en) begin
      read_data_d = read_value;
    end

    // A RELOAD write wins over a tick in the same cycle; that tick is dropped
    if (wr_reload) begin
      reload_d = io_write_data[COUNTER_WIDTH-1:0];
      count_d  = io_write_data[COUNTER_WIDTH-1:0];
    end else if (tick) begin
      if (count_q == CNT_ONE) begin
        expire  = 1'b1;
        count_d = auto_reload_q ? reload_q : '0;
      end else if (count_q != '0) begin
        count_d = count_q - CNT_ONE;
      end
    end

    // An expiry beats any STATUS clear in the same cycle: expired stays set
    // and miss_count is left alone, whichever clear bits were written
    if (expire) begin
      expired_d = 1'b1;
      if (expired_q && !clear_expired && !clear_miss &&
          (miss_count_q != MISS_COUNT_MAX)) begin
        miss_count_d = miss_count_q + MISS_COUNT_WIDTH'(1);
      end
    end else begin
      if (clear_expired) begin
        expired_d = 1'b0;
      end
      if (clear_miss) begin
        miss_count_d = '0;
      end
    end

    // Enable changes only after this edge, so a tick now is still applied
    if (wr_control) begin
      enable_d      = io_write_data[CTRL_ENABLE_BIT];
      auto_reload_d = io_write_data[CTRL_AUTO_RELOAD_BIT];
    end

    timer_expired_d = expired_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q        <= 1'b0;
      auto_reload_q   <= 1'b0;
      reload_q        <= '0;
      count_q         <= '0;
      expired_q       <= 1'b0;
      miss_count_q    <= '0;
      read_data_q     <= '0;
      timer_expired_q <= 1'b0;
    end else begin
      enable_q        <= enable_d;
      auto_reload_q   <= auto_reload_d;
      reload_q        <= reload_d;
      count_q         <= count_d;
      expired_q       <= expired_d;
      miss_count_q    <= miss_count_d;
      read_data_q     <= read_data_d;
      timer_expired_q <= timer_expired_d;
    end
  end

  assign io_read_data  = read_data_q;
  assign timer_expired = timer_expired_q;

endmodule

// File: tb/tb_io_interval_timer.sv
// tb_io_interval_timer
//   Self-checking bench for io_interval_timer (PRESCALE=4). A behavioural
//   model of the register map runs alongside the DUT and every cycle's read
//   data and timer_expired are compared with it; directed sequences also
//   check hand-computed constants, then a randomized bus phase follows.
module tb_io_interval_timer;
  import io_interval_timer_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          PRE  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] io_address = '0;
  logic        io_read_en = 1'b0;
  logic        io_write_en = 1'b0;
  logic [31:0] io_write_data = '0;
  logic [31:0] io_read_data;
  logic        timer_expired;

  int compareCount = 0;
  int mismatchCount = 0;
  bit checking = 1'b0;

  // Reference model state
  bit          mEnable, mAuto, mExpired, mTexp;
  logic [31:0] mReload, mCount, mRdata;
  int          mPre, mMiss;

  io_interval_timer #(
    .BASE_ADDRESS (BASE),
    .PRESCALE     (PRE),
    .COUNTER_WIDTH(32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .io_address   (io_address),
    .io_read_en   (io_read_en),
    .io_write_en  (io_write_en),
    .io_write_data(io_write_data),
    .io_read_data (io_read_data),
    .timer_expired(timer_expired)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] addr);
    logic [31:0] v;
    v = '0;
    if (addr == BASE + TIMER_CONTROL)     v = {30'b0, mAuto, mEnable};
    else if (addr == BASE + TIMER_RELOAD) v = mReload;
    else if (addr == BASE + TIMER_COUNT)  v = mCount;
    else if (addr == BASE + TIMER_STATUS) v = {16'b0, 8'(mMiss), 7'b0, mExpired};
    return v;
  endfunction

  // Model advances on each rising edge from the bus values driven at the falling edge
  always @(posedge clk) begin : refModel
    bit tick, expire, wrReload, wrStatus, clrE, clrM;
    if (reset) begin
      mEnable = 0; mAuto = 0; mExpired = 0; mTexp = 0;
      mReload = 0; mCount = 0; mRdata = 0; mPre = 0; mMiss = 0;
    end else begin
      tick = mEnable && (mPre == PRE - 1);
      if (io_read_en) mRdata = modelRead(io_address);
      wrReload = io_write_en && (io_address == BASE + TIMER_RELOAD);
      wrStatus = io_write_en && (io_address == BASE + TIMER_STATUS);
      clrE = wrStatus && io_write_data[0];
      clrM = wrStatus && io_write_data[1];
      expire = 0;
      if (wrReload) begin
        mReload = io_write_data;
        mCount  = io_write_data;
        mPre    = 0;
      end else begin
        mPre = mEnable ? (mPre + 1) % PRE : 0;
        if (tick && mCount > 1) begin
          mCount = mCount - 1;
        end else if (tick && mCount == 1) begin
          expire = 1;
          mCount = mAuto ? mReload : 0;
        end
      end
      if (expire) begin
        if (mExpired && !clrE && !clrM && mMiss < 255) mMiss = mMiss + 1;
        mExpired = 1;
      end else begin
        if (clrE) mExpired = 0;
        if (clrM) mMiss = 0;
      end
      if (io_write_en && io_address == BASE + TIMER_CONTROL) begin
        mEnable = io_write_data[0];
        mAuto   = io_write_data[1];
      end
      mTexp = mExpired;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("rdata_vs_model", io_read_data, mRdata);
      checkOutput("texp_vs_model", {31'b0, timer_expired}, {31'b0, mTexp});
    end
  end

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    io_address = addr; io_write_data = data; io_write_en = 1'b1;
    @(negedge clk);
    io_write_en = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    io_address = addr; io_read_en = 1'b1;
    @(negedge clk);
    io_read_en = 1'b0;
    data = io_read_data;
  endtask

  task automatic applyStimulus(input int cycles);
    int r, idx;
    logic [31:0] addr;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      io_read_en = 1'b0; io_write_en = 1'b0; reset = 1'b0;
      r   = int'($urandom_range(0, 99));
      idx = int'($urandom_range(0, 5));
      case (idx)
        0: addr = BASE + TIMER_CONTROL;
        1: addr = BASE + TIMER_RELOAD;
        2: addr = BASE + TIMER_COUNT;
        3: addr = BASE + TIMER_STATUS;
        4: addr = BASE + 32'd16;
        default: addr = $urandom;
      endcase
      io_address    = addr;
      io_write_data = (idx == 1) ? 32'($urandom_range(0, 6)) : $urandom;
      if (r < 40) io_read_en = 1'b1;
      else if (r < 70) io_write_en = 1'b1;
      else if (r < 80) begin io_read_en = 1'b1; io_write_en = 1'b1; end
      else if (r == 99) reset = 1'b1;
    end
    @(negedge clk);
    io_read_en = 1'b0; io_write_en = 1'b0; reset = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checking = 1'b1;

    // Reset values of all four registers
    busRead(BASE + TIMER_CONTROL, d); checkOutput("rst_control", d, 32'd0);
    busRead(BASE + TIMER_RELOAD, d);  checkOutput("rst_reload", d, 32'd0);
    busRead(BASE + TIMER_COUNT, d);   checkOutput("rst_count", d, 32'd0);
    busRead(BASE + TIMER_STATUS, d);  checkOutput("rst_status", d, 32'd0);
    checkOutput("rst_texp", {31'b0, timer_expired}, 32'd0);

    // One-shot countdown from 3; enable write sampled at edge E0
    busWrite(BASE + TIMER_RELOAD, 32'd3);
    busWrite(BASE + TIMER_CONTROL, 32'd1);
    repeat (3) @(negedge clk);
    busRead(BASE + TIMER_COUNT, d); checkOutput("oneshot_cnt2", d, 32'd2);
    repeat (2) @(negedge clk);
    busRead(BASE + TIMER_COUNT, d); checkOutput("oneshot_cnt1a", d, 32'd1);
    busRead(BASE + TIMER_COUNT, d); checkOutput("oneshot_cnt1b", d, 32'd1);
    checkOutput("oneshot_texp_pre", {31'b0, timer_expired}, 32'd0);
    @(negedge clk);
    checkOutput("oneshot_texp_at12", {31'b0, timer_expired}, 32'd1);
    busRead(BASE + TIMER_COUNT, d); checkOutput("oneshot_cnt0", d, 32'd0);
    repeat (8) @(negedge clk);
    busRead(BASE + TIMER_COUNT, d); checkOutput("oneshot_cnt0_hold", d, 32'd0);
    busRead(BASE + TIMER_STATUS, d); checkOutput("oneshot_status", d, 32'h1);

    // Auto-reload, five expiries without clearing
    applyReset();
    busWrite(BASE + TIMER_RELOAD, 32'd2);
    busWrite(BASE + TIMER_CONTROL, 32'd3);
    repeat (41) @(negedge clk);
    busRead(BASE + TIMER_STATUS, d); checkOutput("auto_miss4", d, 32'h0000_0401);
    busWrite(BASE + TIMER_STATUS, 32'd3);
    busRead(BASE + TIMER_STATUS, d); checkOutput("auto_cleared", d, 32'h0);
    busWrite(BASE + TIMER_CONTROL, 32'd0);

    // STATUS clear landing on an expiry edge
    applyReset();
    busWrite(BASE + TIMER_RELOAD, 32'd1);
    busWrite(BASE + TIMER_CONTROL, 32'd3);
    repeat (10) @(negedge clk);
    busWrite(BASE + TIMER_STATUS, 32'd1);
    busWrite(BASE + TIMER_CONTROL, 32'd0);
    busRead(BASE + TIMER_STATUS, d); checkOutput("clear_vs_expiry", d, 32'h0000_0101);

    // RELOAD write on a tick edge, then a mid-period RELOAD write
    applyReset();
    busWrite(BASE + TIMER_RELOAD, 32'd9);
    busWrite(BASE + TIMER_CONTROL, 32'd1);
    repeat (6) @(negedge clk);
    busWrite(BASE + TIMER_RELOAD, 32'd5);
    busRead(BASE + TIMER_COUNT, d); checkOutput("reload_on_tick", d, 32'd5);
    busRead(BASE + TIMER_COUNT, d); checkOutput("reload_hold", d, 32'd5);
    busRead(BASE + TIMER_COUNT, d); checkOutput("reload_dec", d, 32'd4);
    @(negedge clk);
    busWrite(BASE + TIMER_RELOAD, 32'd7);
    repeat (2) @(negedge clk);
    busRead(BASE + TIMER_COUNT, d); checkOutput("prescale_restart", d, 32'd7);
    busRead(BASE + TIMER_COUNT, d); checkOutput("after_restart", d, 32'd6);

    // Out-of-range read returns 0; reset in the middle of a count
    busRead(BASE + TIMER_COUNT, d);
    busRead(BASE + 32'd16, d); checkOutput("unmapped_read", d, 32'd0);
    applyReset();
    busRead(BASE + TIMER_COUNT, d);   checkOutput("midreset_count", d, 32'd0);
    busRead(BASE + TIMER_CONTROL, d); checkOutput("midreset_control", d, 32'd0);

    // miss_count saturates at 255
    busWrite(BASE + TIMER_RELOAD, 32'd1);
    busWrite(BASE + TIMER_CONTROL, 32'd3);
    repeat (260 * PRE + 8) @(negedge clk);
    busRead(BASE + TIMER_STATUS, d); checkOutput("miss_saturate", d, 32'h0000_FF01);
    applyReset();

    applyStimulus(3000);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
